// File: rtl/sdram_seq.sv
// SDRAM command sequencer: power-up init, then refresh-first arbitration of single-burst reads/writes.
// Define SDRAM_SEQ_RR_EN for round-robin write/read arbitration (default: fixed write > read).
module sdram_seq #(
    parameter int T_PWRUP = 20000,
    parameter int T_REFI  = 780
) (
    input  logic        CLK_100M,
    input  logic        RST_N,
    input  logic        WR_REQ,
    input  logic [21:0] WR_ADDR,
    input  logic        RD_REQ,
    input  logic [21:0] RD_ADDR,
    output logic [3:0]  INIT_NS,
    output logic [3:0]  WORK_NS,
    output logic [3:0]  TIME_CNT_N,
    output logic [21:0] SDRAM_ADDR_IN,
    output logic        WR_ACK,
    output logic        RD_ACK,
    output logic        WR_DATA_REQ,
    output logic        RD_VALID,
    output logic        INIT_DONE,
    output logic        BUSY
);
    localparam logic [3:0] INIT_PWRUP = 4'h0, INIT_PRECH = 4'h1, INIT_MRS = 4'hA, INIT_FIN = 4'hB;
    localparam logic [3:0] W_IDLE = 4'd0, W_ACT = 4'd1, W_RCD = 4'd2, W_READ = 4'd3, W_CL = 4'd4,
                           W_RDB = 4'd5, W_RP = 4'd6, W_WRITE = 4'd7, W_WRRP = 4'd8, W_REF = 4'd9;
    localparam int REF_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam logic [REF_W-1:0] REF_LAST   = REF_W'(T_REFI - 1);
    localparam logic [14:0]      PWRUP_LAST = 15'(T_PWRUP - 1);

    logic [3:0]       init_ns_reg, init_ns_next;
    logic [3:0]       work_ns_reg, work_ns_next;
    logic [3:0]       time_cnt_reg, time_cnt_next;
    logic [14:0]      pwrup_cnt_reg;
    logic [REF_W-1:0] ref_cnt_reg;
    logic             ref_wrap, ref_pend_reg;
    logic             is_wr_reg;
    logic             grant_ref, grant_wr, grant_rd, wr_win;
    logic [21:0]      addr_reg;
    logic             wr_ack_reg, rd_ack_reg, wr_data_req_reg, rd_valid_reg, init_done_reg;

`ifdef SDRAM_SEQ_RR_EN
    logic last_wr_reg;

    // On a tie the type granted last yields; refresh still wins over both
    always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N)
            last_wr_reg <= 1'b0;
        else if (grant_wr || grant_rd)
            last_wr_reg <= grant_wr;
    end

    assign wr_win = WR_REQ && (!RD_REQ || !last_wr_reg);
`else
    assign wr_win = WR_REQ;
`endif

    always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
            init_ns_reg  <= INIT_PWRUP;
            work_ns_reg  <= W_IDLE;
            time_cnt_reg <= 4'd0;
        end else begin
            init_ns_reg  <= init_ns_next;
            work_ns_reg  <= work_ns_next;
            time_cnt_reg <= time_cnt_next;
        end
    end

    always_comb begin
        init_ns_next = init_ns_reg;
        case (init_ns_reg)
            INIT_PWRUP: if (pwrup_cnt_reg == PWRUP_LAST) init_ns_next = INIT_PRECH;
            INIT_PRECH: if (time_cnt_reg == 4'd2) init_ns_next = 4'h2;
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9:
                        if (time_cnt_reg == 4'd7) init_ns_next = init_ns_reg + 4'd1;
            INIT_MRS:   if (time_cnt_reg == 4'd2) init_ns_next = INIT_FIN;
            INIT_FIN:   init_ns_next = INIT_FIN;
            default:    init_ns_next = INIT_PWRUP;
        endcase
    end

    always_comb begin
        work_ns_next = work_ns_reg;
        grant_ref    = 1'b0;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        case (work_ns_reg)
            W_IDLE: if (init_ns_reg == INIT_FIN) begin
                if (ref_pend_reg) begin
                    grant_ref    = 1'b1;
                    work_ns_next = W_REF;
                end else if (wr_win) begin
                    grant_wr     = 1'b1;
                    work_ns_next = W_ACT;
                end else if (RD_REQ) begin
                    grant_rd     = 1'b1;
                    work_ns_next = W_ACT;
                end
            end
            W_ACT:   if (time_cnt_reg == 4'd0) work_ns_next = W_RCD;
            W_RCD:   if (time_cnt_reg == 4'd1) work_ns_next = is_wr_reg ? W_WRITE : W_READ;
            W_READ:  if (time_cnt_reg == 4'd0) work_ns_next = W_CL;
            W_CL:    if (time_cnt_reg == 4'd2) work_ns_next = W_RDB;
            W_RDB:   if (time_cnt_reg == 4'd7) work_ns_next = W_RP;
            W_RP:    if (time_cnt_reg == 4'd1) work_ns_next = W_IDLE;
            W_WRITE: if (time_cnt_reg == 4'd7) work_ns_next = W_WRRP;
            W_WRRP:  if (time_cnt_reg == 4'd3) work_ns_next = W_IDLE;
            W_REF:   if (time_cnt_reg == 4'd7) work_ns_next = W_IDLE;
            default: work_ns_next = W_IDLE;
        endcase
    end

    always_comb begin
        if (init_ns_next != init_ns_reg || work_ns_next != work_ns_reg)
            time_cnt_next = 4'd0;
        else if (time_cnt_reg == 4'hF)
            time_cnt_next = 4'hF;
        else
            time_cnt_next = time_cnt_reg + 4'd1;
    end

    assign ref_wrap = (ref_cnt_reg == REF_LAST);

    // A wrap coinciding with the refresh grant re-arms the request for the next interval
    always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
            pwrup_cnt_reg <= 15'd0;
            ref_cnt_reg   <= '0;
            ref_pend_reg  <= 1'b0;
        end else begin
            if (init_ns_reg == INIT_PWRUP && pwrup_cnt_reg != PWRUP_LAST)
                pwrup_cnt_reg <= pwrup_cnt_reg + 15'd1;
            ref_cnt_reg  <= ref_wrap ? '0 : ref_cnt_reg + REF_W'(1);
            ref_pend_reg <= (ref_pend_reg && !grant_ref) || (ref_wrap && init_done_reg);
        end
    end

    always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
            addr_reg        <= 22'd0;
            is_wr_reg       <= 1'b0;
            wr_ack_reg      <= 1'b0;
            rd_ack_reg      <= 1'b0;
            wr_data_req_reg <= 1'b0;
            rd_valid_reg    <= 1'b0;
            init_done_reg   <= 1'b0;
        end else begin
            if (grant_wr)
                addr_reg <= WR_ADDR;
            else if (grant_rd)
                addr_reg <= RD_ADDR;
            if (grant_wr || grant_rd)
                is_wr_reg <= grant_wr;
            wr_ack_reg      <= grant_wr;
            rd_ack_reg      <= grant_rd;
            wr_data_req_reg <= (work_ns_next == W_WRITE);
            rd_valid_reg    <= (work_ns_next == W_RDB);
            init_done_reg   <= (init_ns_next == INIT_FIN);
        end
    end

    assign INIT_NS       = init_ns_reg;
    assign WORK_NS       = work_ns_reg;
    assign TIME_CNT_N    = time_cnt_reg;
    assign SDRAM_ADDR_IN = addr_reg;
    assign WR_ACK        = wr_ack_reg;
    assign RD_ACK        = rd_ack_reg;
    assign WR_DATA_REQ   = wr_data_req_reg;
    assign RD_VALID      = rd_valid_reg;
    assign INIT_DONE     = init_done_reg;
    assign BUSY          = !(init_done_reg && work_ns_reg == W_IDLE);
endmodule

// File: tb/tb_sdram_seq.sv
// Bench for sdram_seq: init trace, table of read/write transactions, reset mid-burst,
// and a short-refresh-interval instance under continuous write load.
`timescale 1ns/1ps
module tb_sdram_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, wr_req, rd_req;
    logic [21:0] wr_addr, rd_addr, sdram_addr;
    logic [3:0]  init_ns, work_ns, time_cnt;
    logic        wr_ack, rd_ack, wr_data_req, rd_valid, init_done, busy;

    logic        rst_n_r, wr_req_r, rd_req_r;
    logic [21:0] wr_addr_r, rd_addr_r, sdram_addr_r;
    logic [3:0]  init_ns_r, work_ns_r, time_cnt_r;
    logic        wr_ack_r, rd_ack_r, wr_data_req_r, rd_valid_r, init_done_r, busy_r;

    sdram_seq #(.T_PWRUP(20), .T_REFI(1000)) dut (
        .CLK_100M(clk), .RST_N(rst_n), .WR_REQ(wr_req), .WR_ADDR(wr_addr),
        .RD_REQ(rd_req), .RD_ADDR(rd_addr), .INIT_NS(init_ns), .WORK_NS(work_ns),
        .TIME_CNT_N(time_cnt), .SDRAM_ADDR_IN(sdram_addr), .WR_ACK(wr_ack), .RD_ACK(rd_ack),
        .WR_DATA_REQ(wr_data_req), .RD_VALID(rd_valid), .INIT_DONE(init_done), .BUSY(busy)
    );

    sdram_seq #(.T_PWRUP(20), .T_REFI(50)) dut_r (
        .CLK_100M(clk), .RST_N(rst_n_r), .WR_REQ(wr_req_r), .WR_ADDR(wr_addr_r),
        .RD_REQ(rd_req_r), .RD_ADDR(rd_addr_r), .INIT_NS(init_ns_r), .WORK_NS(work_ns_r),
        .TIME_CNT_N(time_cnt_r), .SDRAM_ADDR_IN(sdram_addr_r), .WR_ACK(wr_ack_r), .RD_ACK(rd_ack_r),
        .WR_DATA_REQ(wr_data_req_r), .RD_VALID(rd_valid_r), .INIT_DONE(init_done_r), .BUSY(busy_r)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // {INIT_NS, WORK_NS, TIME_CNT_N, SDRAM_ADDR_IN, WR_ACK, RD_ACK, WR_DATA_REQ, RD_VALID, INIT_DONE, BUSY}
    localparam logic [39:0] RESET_OUTS = 40'h1;
    function automatic logic [39:0] outs();
        return {init_ns, work_ns, time_cnt, sdram_addr, wr_ack, rd_ack, wr_data_req, rd_valid, init_done, busy};
    endfunction

    typedef struct {
        logic        wr;
        logic        rd;
        logic [21:0] waddr;
        logic [21:0] raddr;
        logic        exp_wr;
        logic        glitch;
    } vec_t;
    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int idx);
        int n, addr_bad, dq_bad, rv_bad, dq_n, rv_n, busy_bad, extra_ack, idle_bad;
        int sc[16];
        logic [31:0] seq;
        logic [39:0] cnts;
        logic [21:0] exp_addr;
        exp_addr = v.exp_wr ? v.waddr : v.raddr;
        addr_bad = 0; dq_bad = 0; rv_bad = 0; dq_n = 0; rv_n = 0; busy_bad = 0; extra_ack = 0; idle_bad = 0;
        for (int i = 0; i < 16; i++) sc[i] = 0;
        seq = 32'h0;
        @(negedge clk);
        wr_req = v.wr; wr_addr = v.waddr; rd_req = v.rd; rd_addr = v.raddr;
        n = 0;
        while (!wr_ack && !rd_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d_ack", idx), 64'({wr_ack, rd_ack}), 64'({v.exp_wr, !v.exp_wr}));
        check($sformatf("v%0d_grant_addr", idx), 64'(sdram_addr), 64'(exp_addr));
        wr_req = 1'b0; rd_req = 1'b0;
        n = 0;
        while (work_ns != 4'd0 && n < 40) begin
            sc[work_ns]++;
            if (seq[3:0] != work_ns) seq = {seq[27:0], work_ns};
            if (sdram_addr !== exp_addr) addr_bad++;
            if (wr_data_req !== (work_ns == 4'd7)) dq_bad++;
            if (rd_valid !== (work_ns == 4'd5)) rv_bad++;
            if (wr_data_req) dq_n++;
            if (rd_valid) rv_n++;
            if (busy !== 1'b1) busy_bad++;
            if (n > 0 && (wr_ack || rd_ack)) extra_ack++;
            if (v.glitch) rd_req = (n >= 3 && n < 6);
            @(negedge clk);
            n++;
        end
        rd_req = 1'b0;
        seq = {seq[27:0], work_ns};
        for (int i = 0; i < 10; i++) cnts[i*4 +: 4] = sc[i][3:0];
        check($sformatf("v%0d_state_order", idx), 64'(seq), v.exp_wr ? 64'h12780 : 64'h1234560);
        check($sformatf("v%0d_state_cycles", idx), 64'(cnts), v.exp_wr ? 64'h0480000210 : 64'h0002831210);
        check($sformatf("v%0d_addr_unstable", idx), 64'(addr_bad), 64'd0);
        check($sformatf("v%0d_wr_data_req_cycles", idx), 64'(dq_n), v.exp_wr ? 64'd8 : 64'd0);
        check($sformatf("v%0d_rd_valid_cycles", idx), 64'(rv_n), v.exp_wr ? 64'd0 : 64'd8);
        check($sformatf("v%0d_beat_misaligned", idx), 64'(dq_bad + rv_bad), 64'd0);
        check($sformatf("v%0d_busy_low", idx), 64'(busy_bad), 64'd0);
        check($sformatf("v%0d_extra_ack", idx), 64'(extra_ack), 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (work_ns !== 4'd0 || wr_ack || rd_ack || busy) idle_bad++;
            @(negedge clk);
        end
        check($sformatf("v%0d_idle_after", idx), 64'(idle_bad), 64'd0);
        $display("vec %0d: %s granted addr=0x%06h order=0x%0h cycles=%0d", idx,
                 v.exp_wr ? "WR" : "RD", exp_addr, seq, n);
    endtask

    initial begin
        int n, tc_bad, max_tc0, ack_bad, visits, run7, run9, burst_bad, idle_run, idle_bad, early_bad;
        logic [63:0] iseq;
        logic [3:0]  prev;
        logic [3:0]  s19, s20;
        logic        rr;

        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_addr = 22'd0; rd_addr = 22'd0;
        rst_n_r = 1'b0; wr_req_r = 1'b1; rd_req_r = 1'b0; wr_addr_r = 22'h155AA0; rd_addr_r = 22'd0;
`ifdef SDRAM_SEQ_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        vecs[0] = '{wr: 1'b1, rd: 1'b0, waddr: 22'h2ABCDE, raddr: 22'h000000, exp_wr: 1'b1, glitch: 1'b1};
        vecs[1] = '{wr: 1'b0, rd: 1'b1, waddr: 22'h000000, raddr: 22'h012345, exp_wr: 1'b0, glitch: 1'b0};
        vecs[2] = '{wr: 1'b1, rd: 1'b0, waddr: 22'h3FFFFF, raddr: 22'h000000, exp_wr: 1'b1, glitch: 1'b0};
        vecs[3] = '{wr: 1'b0, rd: 1'b1, waddr: 22'h000000, raddr: 22'h000000, exp_wr: 1'b0, glitch: 1'b0};
        vecs[4] = '{wr: 1'b1, rd: 1'b1, waddr: 22'h111111, raddr: 22'h222222, exp_wr: 1'b1, glitch: 1'b0};
        vecs[5] = '{wr: 1'b1, rd: 1'b1, waddr: 22'h155555, raddr: 22'h0AAAAA, exp_wr: !rr, glitch: 1'b0};
        vecs[6] = '{wr: 1'b1, rd: 1'b1, waddr: 22'h0C0FFE, raddr: 22'h3BEEF0, exp_wr: 1'b1, glitch: 1'b0};

        repeat (3) @(negedge clk);
        check("reset_outs", 64'(outs()), 64'(RESET_OUTS));

        // Init trace
        rst_n = 1'b1;
        n = 0; iseq = 64'h0; prev = 4'h0; tc_bad = 0; max_tc0 = 0; ack_bad = 0;
        while (!init_done && n < 200) begin
            @(negedge clk);
            n++;
            if (init_ns != prev) begin
                iseq = {iseq[59:0], init_ns};
                if (time_cnt != 4'd0) tc_bad++;
                prev = init_ns;
            end else if (init_ns == 4'h0 && int'(time_cnt) > max_tc0) begin
                max_tc0 = int'(time_cnt);
            end
            if (work_ns != 4'd0 || wr_ack || rd_ack) ack_bad++;
        end
        check("init_done_cycles", 64'(n), 64'd90);
        check("init_state_order", iseq, 64'h0123456789AB);
        check("init_final_state", 64'(init_ns), 64'hB);
        check("time_cnt_clear_on_change", 64'(tc_bad), 64'd0);
        check("time_cnt_saturates", 64'(max_tc0), 64'hF);
        check("work_idle_during_init", 64'(ack_bad), 64'd0);
        $display("init: INIT_DONE after %0d cycles, order=0x%0h", n, iseq);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset pulse in the middle of a write burst
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 22'h0F0F0F;
        n = 0;
        while (!wr_ack && n < 20) begin @(negedge clk); n++; end
        wr_req = 1'b0;
        n = 0;
        while (work_ns != 4'd7 && n < 20) begin @(negedge clk); n++; end
        check("pre_reset_in_burst", 64'({work_ns, wr_data_req, init_done}), 64'({4'd7, 1'b1, 1'b1}));
        #2 rst_n = 1'b0;
        #1 check("async_reset_outs", 64'(outs()), 64'(RESET_OUTS));
        repeat (2) @(negedge clk);
        check("held_reset_outs", 64'(outs()), 64'(RESET_OUTS));
        rst_n = 1'b1;
        s19 = 4'hF; s20 = 4'hF;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 19) s19 = init_ns;
            if (i == 20) s20 = init_ns;
        end
        check("restart_pwrup_wait", 64'(s19), 64'h0);
        check("restart_precharge", 64'(s20), 64'h1);
        $display("reset mid-burst: init restarted, INIT_NS %0h -> %0h at cycle 20", s19, s20);

        // Short refresh interval, continuous write requests
        @(negedge clk);
        rst_n_r = 1'b1;
        visits = 0; run7 = 0; run9 = 0; burst_bad = 0; idle_run = 0; idle_bad = 0; early_bad = 0;
        prev = 4'd0;
        for (int i = 1; i <= 430; i++) begin
            @(negedge clk);
            if (!init_done_r && (wr_ack_r || work_ns_r != 4'd0)) early_bad++;
            if (work_ns_r == 4'd9 && prev != 4'd9) begin
                visits++;
                if (prev != 4'd0) burst_bad++;
            end
            if (work_ns_r == 4'd7) run7++;
            else begin
                if (run7 != 0 && run7 != 8) burst_bad++;
                run7 = 0;
            end
            if (work_ns_r == 4'd9) run9++;
            else begin
                if (run9 != 0 && run9 != 8) burst_bad++;
                run9 = 0;
            end
            if (init_done_r && work_ns_r == 4'd0) begin
                idle_run++;
                if (idle_run > 1) idle_bad++;
            end else begin
                idle_run = 0;
            end
            prev = work_ns_r;
        end
        check("refresh_visits", 64'(visits), 64'd7);
        check("refresh_no_burst_break", 64'(burst_bad), 64'd0);
        check("refresh_then_grant_next_idle", 64'(idle_bad), 64'd0);
        check("refresh_dut_quiet_in_init", 64'(early_bad), 64'd0);
        $display("refresh: %0d refresh visits in 430 cycles", visits);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
